cpu_debug_loader: RTL and testbench
===================================

# cpu_debug_loader

Board-level loader that writes CPU RAM from the switches. It is the write-side counterpart of the debug display path, which only reads CPU state. The operator keys a start address, then 16-bit words one byte at a time, and each word is written to RAM with the address auto-incremented. While a load session is active the CPU is held. The block sits beside the debugger and drives the RAM's debug write port; its field/phase outputs feed the state display.

## Interface
- p_data_width, 16, RAM word width; must be even; entered as two halves of p_data_width/2 bits.
- p_address_width, 10, RAM address width; must be ≥ p_data_width/2.
- i_w_clk  in  1  main clock; all logic is clocked on its rising edge.
- i_w_reset  in  1  reset; synchronous, active-high.
- i_w_in  in  p_address_width  switch value.
- i_w_load_en  in  1  session enable (level, switch).
- i_w_enter  in  1  confirm field; already debounced, single-cycle pulse.
- i_w_back  in  1  step back one field; already debounced, single-cycle pulse.
- i_w_ram_rdata  in  p_data_width  RAM read data; arrives 1 cycle after o_w_ram_re.
- o_w_ram_we  out  1  RAM write strobe, 1 cycle.
- o_w_ram_re  out  1  RAM read strobe; constant 0 without the macro.
- o_w_ram_addr  out  p_address_width  RAM address (current load pointer).
- o_w_ram_wdata  out  p_data_width  assembled word.
- o_w_cpu_hold  out  1  high while a session is active; the CPU must not step.
- o_w_disp_value  out  p_data_width  field being edited, for display.
- o_w_phase  out  3  current state encoding.
- o_w_words  out  p_address_width+1  words written this session, saturating.
- o_w_error  out  1  sticky readback mismatch.

## Operation
- States: S_OFF, S_ADDR, S_DLO, S_DHI, S_WRITE, plus S_VREQ and S_VCMP with the macro.
- Any state with i_w_load_en=0 → S_OFF next cycle. The session aborts; a partially entered word is discarded and never written.
- S_OFF with i_w_load_en=1 → S_ADDR. On this entry o_w_words←0 and o_w_error←0.
- S_ADDR, enter pulse: addr←i_w_in; → S_DLO.
- S_DLO:
  - enter: data[low half]←i_w_in[p_data_width/2-1:0]; → S_DHI.
  - back: → S_ADDR.
- S_DHI:
  - enter: data[high half]←i_w_in[p_data_width/2-1:0]; → S_WRITE.
  - back: → S_DLO; the low half is kept.
- S_WRITE:
  - o_w_ram_we=1 for exactly this cycle.
  - Without the macro: addr←addr+1, modulo 2^p_address_width (wraps to 0); o_w_words+1, saturating at all-ones; → S_DLO.
  - With the macro: → S_VREQ.
- Simultaneous enter and back: both ignored.
- Pulses in S_WRITE, S_VREQ or S_VCMP are ignored and not queued.
- o_w_disp_value:
  - S_ADDR: i_w_in, zero-extended (live preview).
  - S_DLO / S_DHI: assembled data register, with the half being entered replaced live by i_w_in.
  - Other states: data register.
- o_w_cpu_hold = (state ≠ S_OFF).

## Timing
- Reset: state S_OFF. All outputs 0, including addr, data, o_w_words and o_w_error.
- Reset mid-session wins over everything and drops the word; no write occurs.
- Enter pulse in S_DHI at cycle n → o_w_ram_we=1 at n+1, carrying the new address and data.
- Incremented address is visible:
  - at n+2 without the macro;
  - at n+4 with the macro.
- A session that starts and stops with no completed S_WRITE produces zero writes.

## Configuration
- LOADER_READBACK_EN defined:
  - S_VREQ drives o_w_ram_re=1 for 1 cycle at the same address.
  - S_VCMP compares i_w_ram_rdata with the data register; a mismatch sets o_w_error.
  - Then addr/words increment as above; → S_DLO.
- LOADER_READBACK_EN undefined: the S_VREQ/S_VCMP logic is absent; o_w_ram_re and o_w_error are tied to 0.

## Structure
- State encodings and phase constants live in cpu_debug_pkg, shared with state_display so it can decode o_w_phase.
- Sub-module: loader_readback_check (registered compare plus sticky error), instantiated only under LOADER_READBACK_EN.

## Test plan
- Reset with load_en=1 held → after release: S_ADDR, hold=1, all outputs 0.
- Enter sequence addr 0x3FE, then data bytes 0x34 then 0x12 → we pulses at 0x3FE with 0x1234; second word 0xBEEF lands at 0x3FF; third word lands at 0x000 (wrap); words=3.
- In S_DHI press back, then re-enter low byte 0x55 and high byte 0xAA → written word 0xAA55.
- Drop load_en in S_DHI → S_OFF next cycle, no we, hold=0.
- Enter and back in the same cycle in S_DLO → state and data unchanged.
- With LOADER_READBACK_EN, model returns 0x0000 for a write of 0x1234 → error=1 and stays 1; re-entering a session clears it.

Source files
------------

// File: rtl/cpu_debug_pkg.sv
// Shared state/phase encodings for the CPU debug loader and the state display.
// The display decodes o_w_phase using the PH_* constants below.
package cpu_debug_pkg;

    localparam int LOADER_PHASE_W = 3;

    localparam logic [LOADER_PHASE_W-1:0] PH_OFF   = 3'd0;
    localparam logic [LOADER_PHASE_W-1:0] PH_ADDR  = 3'd1;
    localparam logic [LOADER_PHASE_W-1:0] PH_DLO   = 3'd2;
    localparam logic [LOADER_PHASE_W-1:0] PH_DHI   = 3'd3;
    localparam logic [LOADER_PHASE_W-1:0] PH_WRITE = 3'd4;
    localparam logic [LOADER_PHASE_W-1:0] PH_VREQ  = 3'd5;
    localparam logic [LOADER_PHASE_W-1:0] PH_VCMP  = 3'd6;

    typedef enum logic [LOADER_PHASE_W-1:0] {
        S_OFF   = PH_OFF,
        S_ADDR  = PH_ADDR,
        S_DLO   = PH_DLO,
        S_DHI   = PH_DHI,
        S_WRITE = PH_WRITE,
        S_VREQ  = PH_VREQ,
        S_VCMP  = PH_VCMP
    } loader_state_t;

endpackage

// File: rtl/loader_readback_check.sv
// Registered readback compare with a sticky mismatch flag; cleared when a new
// load session starts. Only instantiated when LOADER_READBACK_EN is defined.
module loader_readback_check #(
    parameter int p_data_width = 16
) (
    input  logic                    i_w_clk,
    input  logic                    i_w_reset,
    input  logic                    i_w_clear,
    input  logic                    i_w_compare,
    input  logic [p_data_width-1:0] i_w_rdata,
    input  logic [p_data_width-1:0] i_w_expected,
    output logic                    o_w_error
);

    logic error_q;

    always_ff @(posedge i_w_clk) begin
        if (i_w_reset || i_w_clear) begin
            error_q <= 1'b0;
        end else if (i_w_compare && (i_w_rdata != i_w_expected)) begin
            error_q <= 1'b1;
        end
    end

    assign o_w_error = error_q;

endmodule

// File: rtl/cpu_debug_loader.sv
// Switch-driven RAM loader: keys an address, then 16-bit words a byte at a time,
// holding the CPU while active. Optional readback verify: LOADER_READBACK_EN.
module cpu_debug_loader
    import cpu_debug_pkg::*;
#(
    parameter int p_data_width    = 16,
    parameter int p_address_width = 10
) (
    input  logic                       i_w_clk,
    input  logic                       i_w_reset,
    input  logic [p_address_width-1:0] i_w_in,
    input  logic                       i_w_load_en,
    input  logic                       i_w_enter,
    input  logic                       i_w_back,
    input  logic [p_data_width-1:0]    i_w_ram_rdata,
    output logic                       o_w_ram_we,
    output logic                       o_w_ram_re,
    output logic [p_address_width-1:0] o_w_ram_addr,
    output logic [p_data_width-1:0]    o_w_ram_wdata,
    output logic                       o_w_cpu_hold,
    output logic [p_data_width-1:0]    o_w_disp_value,
    output logic [2:0]                 o_w_phase,
    output logic [p_address_width:0]   o_w_words,
    output logic                       o_w_error
);

    localparam int HALF_W = p_data_width / 2;
    localparam logic [p_address_width:0]   WORDS_MAX = '1;
    localparam logic [p_address_width-1:0] ADDR_ONE  = p_address_width'(1);
    localparam logic [p_address_width:0]   WORDS_ONE = (p_address_width + 1)'(1);

    loader_state_t state, state_next;

    logic [p_address_width-1:0] addr_q, addr_d;
    logic [p_data_width-1:0]    data_q, data_d;
    logic [p_address_width:0]   words_q, words_d;
    logic                       advance;

    // Simultaneous enter and back cancel each other out.
    logic enter_only, back_only;
    assign enter_only = i_w_enter && !i_w_back;
    assign back_only  = i_w_back && !i_w_enter;

    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            state   <= S_OFF;
            addr_q  <= '0;
            data_q  <= '0;
            words_q <= '0;
        end else begin
            state   <= state_next;
            addr_q  <= addr_d;
            data_q  <= data_d;
            words_q <= words_d;
        end
    end

    always_comb begin
        state_next = state;
        addr_d     = addr_q;
        data_d     = data_q;
        words_d    = words_q;
        advance    = 1'b0;

        if (!i_w_load_en) begin
            state_next = S_OFF;
        end else begin
            case (state)
                S_OFF: begin
                    state_next = S_ADDR;
                    words_d    = '0;
                end
                S_ADDR: begin
                    if (enter_only) begin
                        addr_d     = i_w_in;
                        state_next = S_DLO;
                    end
                end
                S_DLO: begin
                    if (enter_only) begin
                        data_d[HALF_W-1:0] = i_w_in[HALF_W-1:0];
                        state_next         = S_DHI;
                    end else if (back_only) begin
                        state_next = S_ADDR;
                    end
                end
                S_DHI: begin
                    if (enter_only) begin
                        data_d[p_data_width-1:HALF_W] = i_w_in[HALF_W-1:0];
                        state_next                    = S_WRITE;
                    end else if (back_only) begin
                        state_next = S_DLO;
                    end
                end
`ifdef LOADER_READBACK_EN
                S_WRITE: state_next = S_VREQ;
                S_VREQ:  state_next = S_VCMP;
                S_VCMP: begin
                    advance    = 1'b1;
                    state_next = S_DLO;
                end
`else
                S_WRITE: begin
                    advance    = 1'b1;
                    state_next = S_DLO;
                end
`endif
                default: state_next = S_OFF;
            endcase
        end

        // Pointer wraps; word count saturates so the display never rolls over.
        if (advance) begin
            addr_d = addr_q + ADDR_ONE;
            if (words_q != WORDS_MAX) begin
                words_d = words_q + WORDS_ONE;
            end
        end
    end

    // The half currently being keyed is previewed live from the switches.
    always_comb begin
        o_w_disp_value = data_q;
        case (state)
            S_ADDR:  o_w_disp_value = p_data_width'(i_w_in);
            S_DLO:   o_w_disp_value = {data_q[p_data_width-1:HALF_W], i_w_in[HALF_W-1:0]};
            S_DHI:   o_w_disp_value = {i_w_in[HALF_W-1:0], data_q[HALF_W-1:0]};
            default: o_w_disp_value = data_q;
        endcase
    end

    assign o_w_ram_we    = (state == S_WRITE) && !i_w_reset;
    assign o_w_ram_addr  = addr_q;
    assign o_w_ram_wdata = data_q;
    assign o_w_cpu_hold  = (state != S_OFF);
    assign o_w_phase     = state;
    assign o_w_words     = words_q;

`ifdef LOADER_READBACK_EN
    logic session_start;
    assign session_start = (state == S_OFF) && i_w_load_en;
    assign o_w_ram_re    = (state == S_VREQ) && !i_w_reset;

    loader_readback_check #(
        .p_data_width (p_data_width)
    ) u_readback_check (
        .i_w_clk      (i_w_clk),
        .i_w_reset    (i_w_reset),
        .i_w_clear    (session_start),
        .i_w_compare  (state == S_VCMP),
        .i_w_rdata    (i_w_ram_rdata),
        .i_w_expected (data_q),
        .o_w_error    (o_w_error)
    );
`else
    logic rdata_unused;
    assign rdata_unused = ^i_w_ram_rdata;
    assign o_w_ram_re   = 1'b0;
    assign o_w_error    = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_debug_loader.sv
// Self-checking bench for cpu_debug_loader: directed load sessions followed by
// random switch/button activity, compared against a field-level loader model.
module tb_cpu_debug_loader;
    import cpu_debug_pkg::*;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int HW = DW / 2;
`ifdef LOADER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int WR_CYC = RB ? 3 : 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] sw;
    logic          load_en, enter, back;
    logic [DW-1:0] ram_rdata = '0;
    logic          ram_we, ram_re, cpu_hold, error;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, disp_value;
    logic [2:0]    phase;
    logic [AW:0]   words;

    always #5 clk = ~clk;

    cpu_debug_loader #(.p_data_width(DW), .p_address_width(AW)) dut (
        .i_w_clk        (clk),
        .i_w_reset      (reset),
        .i_w_in         (sw),
        .i_w_load_en    (load_en),
        .i_w_enter      (enter),
        .i_w_back       (back),
        .i_w_ram_rdata  (ram_rdata),
        .o_w_ram_we     (ram_we),
        .o_w_ram_re     (ram_re),
        .o_w_ram_addr   (ram_addr),
        .o_w_ram_wdata  (ram_wdata),
        .o_w_cpu_hold   (cpu_hold),
        .o_w_disp_value (disp_value),
        .o_w_phase      (phase),
        .o_w_words      (words),
        .o_w_error      (error)
    );

    // Behavioural RAM: 1-cycle read latency, optional forced-zero readback.
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    int            write_count;
    bit            rd_corrupt = 1'b0;

    always @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
            write_count       <= write_count + 1;
        end
        if (ram_re) ram_rdata <= rd_corrupt ? '0 : ram_mem[ram_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Loader model: which field the operator is keying, pointer, word, count.
    logic [2:0]    m_phase = PH_OFF;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    int            m_words = 0;
    bit            m_err = 1'b0;
    bit            m_rd_corrupt = 1'b0;

    task automatic bumpPointer();
        m_addr = m_addr + 1'b1;
        if (m_words < (1 << (AW + 1)) - 1) m_words++;
    endtask

    task automatic modelEdge(input logic rst, input logic le, input logic e, input logic b, input logic [AW-1:0] v);
        bit eo, bo;
        eo = e && !b;
        bo = b && !e;
        if (rst) begin
            m_phase = PH_OFF; m_addr = '0; m_data = '0; m_words = 0; m_err = 1'b0;
        end else if (!le) begin
            m_phase = PH_OFF;
        end else begin
            case (m_phase)
                PH_OFF:  begin m_phase = PH_ADDR; m_words = 0; m_err = 1'b0; end
                PH_ADDR: if (eo) begin m_addr = v; m_phase = PH_DLO; end
                PH_DLO: begin
                    if (eo) begin m_data[HW-1:0] = v[HW-1:0]; m_phase = PH_DHI; end
                    else if (bo) m_phase = PH_ADDR;
                end
                PH_DHI: begin
                    if (eo) begin m_data[DW-1:HW] = v[HW-1:0]; m_phase = PH_WRITE; end
                    else if (bo) m_phase = PH_DLO;
                end
                PH_WRITE: begin
                    if (RB) m_phase = PH_VREQ;
                    else begin bumpPointer(); m_phase = PH_DLO; end
                end
                PH_VREQ: begin m_rd_corrupt = rd_corrupt; m_phase = PH_VCMP; end
                PH_VCMP: begin
                    if (m_rd_corrupt && m_data != '0) m_err = 1'b1;
                    bumpPointer();
                    m_phase = PH_DLO;
                end
                default: m_phase = PH_OFF;
            endcase
        end
    endtask

    // One clock: drive, check pre-edge outputs against the model, advance both.
    task automatic applyStimulus(input logic rst, input logic le, input logic e, input logic b, input logic [AW-1:0] v);
        logic [DW-1:0] exp_disp;
        reset = rst; load_en = le; enter = e; back = b; sw = v;
        #1;
        case (m_phase)
            PH_ADDR: exp_disp = {{(DW-AW){1'b0}}, v};
            PH_DLO:  exp_disp = {m_data[DW-1:HW], v[HW-1:0]};
            PH_DHI:  exp_disp = {v[HW-1:0], m_data[HW-1:0]};
            default: exp_disp = m_data;
        endcase
        checkOutput("phase", phase, m_phase);
        checkOutput("cpu_hold", cpu_hold, m_phase != PH_OFF);
        checkOutput("ram_addr", ram_addr, m_addr);
        checkOutput("ram_wdata", ram_wdata, m_data);
        checkOutput("disp_value", disp_value, exp_disp);
        checkOutput("words", words, m_words);
        checkOutput("ram_we", ram_we, (m_phase == PH_WRITE) && !rst);
        checkOutput("ram_re", ram_re, RB && (m_phase == PH_VREQ) && !rst);
        checkOutput("error", error, m_err);
        @(posedge clk);
        modelEdge(rst, le, e, b, v);
        @(negedge clk);
    endtask

    task automatic pressEnter(input logic [AW-1:0] v);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, v);
    endtask

    task automatic idle(input int n, input logic le);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, le, 1'b0, 1'b0, $urandom);
    endtask

    task automatic enterWord(input logic [HW-1:0] lo, input logic [HW-1:0] hi);
        pressEnter({{(AW-HW){1'b0}}, lo});
        pressEnter({{(AW-HW){1'b0}}, hi});
        idle(WR_CYC, 1'b1);
    endtask

    initial begin
        int wc;
        reset = 1'b1; load_en = 1'b1; enter = 1'b0; back = 1'b0; sw = '0;
        @(negedge clk);

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
        checkOutput("reset_to_addr", phase, PH_ADDR);
        checkOutput("reset_hold", cpu_hold, 1'b1);

        // Three words across the top of the address space.
        pressEnter(10'h3FE);
        enterWord(8'h34, 8'h12);
        enterWord(8'hEF, 8'hBE);
        enterWord(8'h78, 8'h56);
        checkOutput("mem_3fe", ram_mem[10'h3FE], 16'h1234);
        checkOutput("mem_3ff", ram_mem[10'h3FF], 16'hBEEF);
        checkOutput("mem_000", ram_mem[10'h000], 16'h5678);
        checkOutput("words_after_wrap", words, 3);

        // Back out of the high byte and re-key the whole word.
        pressEnter(10'h011);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, '0);
        enterWord(8'h55, 8'hAA);
        checkOutput("mem_001_back", ram_mem[10'h001], 16'hAA55);

        // Abort mid-word: nothing may be written.
        pressEnter(10'h077);
        wc = write_count;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("abort_hold", cpu_hold, 1'b0);
        idle(4, 1'b0);
        checkOutput("abort_no_write", write_count, wc);

        // Enter and back together are ignored.
        idle(1, 1'b1);
        pressEnter(10'h100);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 10'h099);
        checkOutput("both_phase", phase, PH_DLO);

`ifdef LOADER_READBACK_EN
        rd_corrupt = 1'b1;
        enterWord(8'h34, 8'h12);
        rd_corrupt = 1'b0;
        checkOutput("rb_error_set", error, 1'b1);
        enterWord(8'h01, 8'h02);
        checkOutput("rb_error_sticky", error, 1'b1);
        idle(1, 1'b0);
        idle(2, 1'b1);
        checkOutput("rb_error_cleared", error, 1'b0);
`endif

        for (int i = 0; i < 800; i++) begin
            if (RB) rd_corrupt = ($urandom_range(0, 3) == 0);
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 29) != 0,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
